// File: rtl/trap_controller_if.sv
// Fetch redirect channel between trap_controller (master) and the fetch stage (slave).
// valid/ready: the master raises redirect_valid_o with a stable redirect_pc_o until
// redirect_ready_i is seen high; the transfer happens in that valid&ready cycle.
interface trap_controller_if;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  modport master (
    output redirect_valid_o,
    output redirect_pc_o,
    input  redirect_ready_i
  );

  modport slave (
    input  redirect_valid_o,
    input  redirect_pc_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer: arbitrate, flush, strobe csr_unit, redirect fetch.
// Optional macro TRAP_VECTORED_EN: interrupts with mtvec mode 01 vector to base + 4*code.
module trap_controller #(
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exc_valid_i,
  input  logic [3:0]        exc_code_i,
  input  logic [31:0]       exc_pc_i,
  input  logic              irq_ext_i,
  input  logic              irq_sw_i,
  input  logic              irq_timer_i,
  input  logic [2:0]        irq_en_i,
  input  logic              mie_i,
  input  logic [31:0]       int_pc_i,
  input  logic              mret_i,
  input  logic [31:0]       mtvec_i,
  input  logic [31:0]       mepc_i,
  output logic              flush_req_o,
  input  logic              flush_ack_i,
  output logic              csr_exception_o,
  output logic [31:0]       csr_exception_pc_o,
  output logic [31:0]       csr_exception_cause_o,
  output logic              csr_mret_o,
  trap_controller_if.master rd,
  output logic              busy_o,
  output logic              flush_timeout_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_RET      = 3'd3,
    ST_REDIRECT = 3'd4
  } state_e;

  localparam int unsigned CW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    cause_q, cause_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
  logic           flush_req_q, flush_req_d;
  logic           exc_stb_q, exc_stb_d;
  logic [31:0]    exc_pc_out_q, exc_pc_out_d;
  logic [31:0]    exc_cause_out_q, exc_cause_out_d;
  logic           mret_stb_q, mret_stb_d;
  logic           rd_valid_q, rd_valid_d;
  logic [31:0]    rd_pc_q, rd_pc_d;
  logic           busy_q, busy_d;

  logic [2:0]     pending;
  logic [3:0]     irq_code;
  logic [CW-1:0]  cnt_inc;
  logic           timeout_hit;
  logic [31:0]    vec_base;
  logic [31:0]    trap_vector;

  always_comb begin
    // pending is ordered by priority: MEI, MSI, MTI
    pending = {irq_ext_i & irq_en_i[2], irq_sw_i & irq_en_i[0], irq_timer_i & irq_en_i[1]};
    if (pending[2])      irq_code = 4'd11;
    else if (pending[1]) irq_code = 4'd3;
    else                 irq_code = 4'd7;

    cnt_inc     = cnt_q + CW'(1);
    timeout_hit = (FLUSH_TIMEOUT != 0) && (cnt_inc == CW'(FLUSH_TIMEOUT));

    vec_base = mtvec_i & ~32'h3;
`ifdef TRAP_VECTORED_EN
    if (cause_q[31] && (mtvec_i[1:0] == 2'b01)) trap_vector = vec_base + {26'b0, cause_q[3:0], 2'b00};
    else                                         trap_vector = vec_base;
`else
    trap_vector = vec_base;
`endif

    state_d   = state_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    rd_pc_d   = rd_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid_i) begin
          pc_d    = exc_pc_i;
          cause_d = {28'b0, exc_code_i};
          state_d = ST_FLUSH;
        end else if (mret_i) begin
          state_d = ST_RET;
        end else if (mie_i && (pending != 3'b000)) begin
          pc_d    = int_pc_i;
          cause_d = {1'b1, 27'b0, irq_code};
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // An ack arriving in the same cycle the budget runs out is a clean drain.
        if (flush_ack_i) begin
          cnt_d   = '0;
          state_d = ST_COMMIT;
        end else if (timeout_hit) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_COMMIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_COMMIT: begin
        rd_pc_d = trap_vector;
        state_d = ST_REDIRECT;
      end
      ST_RET: begin
        rd_pc_d = mepc_i & ~32'h3;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (rd.redirect_ready_i) begin
          rd_pc_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered images of the next state so they line up with it.
    flush_req_d     = (state_d == ST_FLUSH);
    exc_stb_d       = (state_d == ST_COMMIT);
    exc_pc_out_d    = (state_d == ST_COMMIT) ? pc_d : 32'h0;
    exc_cause_out_d = (state_d == ST_COMMIT) ? cause_d : 32'h0;
    mret_stb_d      = (state_d == ST_RET);
    rd_valid_d      = (state_d == ST_REDIRECT);
    busy_d          = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      pc_q            <= '0;
      cause_q         <= '0;
      cnt_q           <= '0;
      timeout_q       <= 1'b0;
      flush_req_q     <= 1'b0;
      exc_stb_q       <= 1'b0;
      exc_pc_out_q    <= '0;
      exc_cause_out_q <= '0;
      mret_stb_q      <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_pc_q         <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      cause_q         <= cause_d;
      cnt_q           <= cnt_d;
      timeout_q       <= timeout_d;
      flush_req_q     <= flush_req_d;
      exc_stb_q       <= exc_stb_d;
      exc_pc_out_q    <= exc_pc_out_d;
      exc_cause_out_q <= exc_cause_out_d;
      mret_stb_q      <= mret_stb_d;
      rd_valid_q      <= rd_valid_d;
      rd_pc_q         <= rd_pc_d;
      busy_q          <= busy_d;
    end
  end

  assign flush_req_o           = flush_req_q;
  assign csr_exception_o       = exc_stb_q;
  assign csr_exception_pc_o    = exc_pc_out_q;
  assign csr_exception_cause_o = exc_cause_out_q;
  assign csr_mret_o            = mret_stb_q;
  assign rd.redirect_valid_o   = rd_valid_q;
  assign rd.redirect_pc_o      = rd_pc_q;
  assign busy_o                = busy_q;
  assign flush_timeout_o       = timeout_q;
  assign dbg_state_o           = state_q;

endmodule
